// File: rtl/ipv_pkg.sv
// Shared types, helpers and legal parameter ranges for the multi-channel IPV reducer.
package ipv_pkg;

  typedef enum logic {
    IPV_THERM = 1'b0,
    IPV_RAW   = 1'b1
  } ipv_mode_e;

  localparam int unsigned IPV_K_MIN     = 2;
  localparam int unsigned IPV_K_MAX     = 16;
  localparam int unsigned IPV_CH_MIN    = 1;
  localparam int unsigned IPV_CH_MAX    = 16;
  localparam int unsigned IPV_STALL_MIN = 1;
  localparam int unsigned IPV_STALL_MAX = 8;

  // Ceiling log2, usable in parameter declarations.
  function automatic int unsigned ipv_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/ipv_lane.sv
// One channel of the IPV reducer: K-bit accumulator plus popcount, exposing next values.
module ipv_lane
  import ipv_pkg::*;
#(
  parameter int unsigned K      = 4,
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned BEAT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              beat0,
  input  logic [BEAT_W-1:0] beat,
  input  ipv_mode_e         mode,
  input  logic              en,
  output logic [K-1:0]      acc_nxt_c,
  output logic [CNT_W-1:0]  cnt_nxt_c
);

  logic [K-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [K-1:0]     acc_base;
  logic [CNT_W-1:0] cnt_base;

  // Beat 0 starts from an empty lane so the previous frame never leaks in.
  always_comb begin
    acc_base  = beat0 ? '0 : acc_q;
    cnt_base  = beat0 ? '0 : cnt_q;
    acc_nxt_c = acc_base;
    if (mode == IPV_THERM) begin
      if (din) acc_nxt_c = {1'b1, acc_base[K-1:1]};
    end else begin
      for (int i = 0; i < int'(K); i++) begin
        if (BEAT_W'(K - 1 - i) == beat) acc_nxt_c[i] = din;
      end
    end
    cnt_nxt_c = cnt_base + CNT_W'(din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (en) begin
      acc_q <= acc_nxt_c;
      cnt_q <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/ipv_reducer_mc.sv
// Multi-channel IPV reducer: shared framing, per-channel lanes, fixed-latency output pipeline.
module ipv_reducer_mc
  import ipv_pkg::*;
#(
  parameter int unsigned K     = 4,
  parameter int unsigned CH    = 2,
  parameter int unsigned STALL = 2,
  parameter int unsigned CNT_W = ipv_clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [CH-1:0]         in_bits,
  input  logic                  mode,
  input  logic                  frame_sync,
  output logic                  vov_valid,
  output logic [CH*K-1:0]       vov,
  output logic [CH*CNT_W-1:0]   vov_cnt,
  output logic                  sync_err
);

  localparam int unsigned BEAT_W = ipv_clog2(K);

  typedef struct packed {
    logic                valid;
    logic [CH*K-1:0]     vov;
    logic [CH*CNT_W-1:0] cnt;
  } stage_t;

  logic [BEAT_W-1:0]   beat_q;
  ipv_mode_e           mode_q;
  logic                sync_err_q;
  stage_t              pipe_q [STALL];

  logic [BEAT_W-1:0]   beat_c;
  logic                beat0_c;
  logic                last_c;
  ipv_mode_e           mode_c;
  logic [K-1:0]        acc_nxt [CH];
  logic [CNT_W-1:0]    cnt_nxt [CH];
  logic [CH*K-1:0]     frame_vov_c;
  logic [CH*CNT_W-1:0] frame_cnt_c;

  // frame_sync re-bases the current beat to 0, which also suppresses completion.
  always_comb begin
    beat_c  = frame_sync ? '0 : beat_q;
    beat0_c = in_valid && (beat_c == '0);
    last_c  = in_valid && (beat_c == BEAT_W'(K - 1));
    mode_c  = beat0_c ? ipv_mode_e'(mode) : mode_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q     <= '0;
      mode_q     <= IPV_THERM;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= frame_sync && (beat_q != '0);
      if (in_valid) begin
        beat_q <= last_c ? '0 : beat_c + BEAT_W'(1);
        if (beat0_c) mode_q <= ipv_mode_e'(mode);
      end else if (frame_sync) begin
        beat_q <= '0;
      end
    end
  end

  for (genvar c = 0; c < int'(CH); c++) begin : g_lane
    ipv_lane #(
      .K      (K),
      .CNT_W  (CNT_W),
      .BEAT_W (BEAT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .din       (in_bits[c]),
      .beat0     (beat0_c),
      .beat      (beat_c),
      .mode      (mode_c),
      .en        (in_valid),
      .acc_nxt_c (acc_nxt[c]),
      .cnt_nxt_c (cnt_nxt[c])
    );
  end

  always_comb begin
    frame_vov_c = '0;
    frame_cnt_c = '0;
    for (int c = 0; c < int'(CH); c++) begin
      frame_vov_c[c*K +: K]         = acc_nxt[c];
      frame_cnt_c[c*CNT_W +: CNT_W] = cnt_nxt[c];
    end
  end

  // Stage 0 captures only on completion, so idle stages carry zeros to the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STALL); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= last_c ? stage_t'{valid: 1'b1, vov: frame_vov_c, cnt: frame_cnt_c} : '0;
      for (int i = 1; i < int'(STALL); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vov_valid = pipe_q[STALL-1].valid;
  assign vov       = pipe_q[STALL-1].vov;
  assign vov_cnt   = pipe_q[STALL-1].cnt;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_ipv_reducer_mc.sv
// Randomized + directed bench for ipv_reducer_mc (STALL=2 and STALL=1 instances on shared inputs).
module tb_ipv_reducer_mc;
  import ipv_pkg::*;

  localparam int unsigned K  = 4;
  localparam int unsigned CH = 2;
  localparam int unsigned CW = ipv_clog2(K + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [CH-1:0] in_bits = '0;
  logic          mode = 1'b0;
  logic          frame_sync = 1'b0;

  logic             vld_a, vld_b, se_a, se_b;
  logic [CH*K-1:0]  vov_a, vov_b;
  logic [CH*CW-1:0] cnt_a, cnt_b;

  ipv_reducer_mc #(.K(K), .CH(CH), .STALL(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits), .mode(mode),
    .frame_sync(frame_sync), .vov_valid(vld_a), .vov(vov_a), .vov_cnt(cnt_a), .sync_err(se_a));

  ipv_reducer_mc #(.K(K), .CH(CH), .STALL(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits), .mode(mode),
    .frame_sync(frame_sync), .vov_valid(vld_b), .vov(vov_b), .vov_cnt(cnt_b), .sync_err(se_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: beats collected per frame, results scheduled by output edge.
  int               nb = 0;
  logic             fmode = 1'b0;
  logic             fb [CH][K];
  logic             exp_se = 1'b0;
  logic [CH*K-1:0]  exp_vov_a [int];
  logic [CH*CW-1:0] exp_cnt_a [int];
  logic [CH*K-1:0]  exp_vov_b [int];
  logic [CH*CW-1:0] exp_cnt_b [int];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    nb = 0;
    exp_se = 1'b0;
    exp_vov_a.delete();
    exp_cnt_a.delete();
    exp_vov_b.delete();
    exp_cnt_b.delete();
  endtask

  task automatic model_edge(input logic v, input logic [CH-1:0] bits, input logic md,
                            input logic fs);
    logic [CH*K-1:0]  vv;
    logic [CH*CW-1:0] cc;
    int               n;
    logic [K-1:0]     raw, therm;
    exp_se = fs && (nb != 0);
    if (fs) nb = 0;
    if (v) begin
      if (nb == 0) fmode = md;
      for (int c = 0; c < int'(CH); c++) fb[c][nb] = bits[c];
      nb++;
      if (nb == int'(K)) begin
        vv = '0;
        cc = '0;
        for (int c = 0; c < int'(CH); c++) begin
          n = 0;
          raw = '0;
          for (int i = 0; i < int'(K); i++) begin
            n += int'(fb[c][i]);
            raw[int'(K) - 1 - i] = fb[c][i];
          end
          therm = K'(((1 << n) - 1) << (int'(K) - n));
          vv[c*K +: K]   = fmode ? raw : therm;
          cc[c*CW +: CW] = CW'(n);
        end
        exp_vov_a[edge_n + 1] = vv;
        exp_cnt_a[edge_n + 1] = cc;
        exp_vov_b[edge_n]     = vv;
        exp_cnt_b[edge_n]     = cc;
        nb = 0;
      end
    end
  endtask

  task automatic check_out();
    if (exp_vov_a.exists(edge_n)) begin
      chk("a_valid", 64'(vld_a), 64'd1);
      chk("a_vov", 64'(vov_a), 64'(exp_vov_a[edge_n]));
      chk("a_cnt", 64'(cnt_a), 64'(exp_cnt_a[edge_n]));
      exp_vov_a.delete(edge_n);
      exp_cnt_a.delete(edge_n);
    end else begin
      chk("a_valid", 64'(vld_a), 64'd0);
      chk("a_vov_idle", 64'(vov_a), 64'd0);
      chk("a_cnt_idle", 64'(cnt_a), 64'd0);
    end
    if (exp_vov_b.exists(edge_n)) begin
      chk("b_valid", 64'(vld_b), 64'd1);
      chk("b_vov", 64'(vov_b), 64'(exp_vov_b[edge_n]));
      chk("b_cnt", 64'(cnt_b), 64'(exp_cnt_b[edge_n]));
      exp_vov_b.delete(edge_n);
      exp_cnt_b.delete(edge_n);
    end else begin
      chk("b_valid", 64'(vld_b), 64'd0);
      chk("b_vov_idle", 64'(vov_b), 64'd0);
      chk("b_cnt_idle", 64'(cnt_b), 64'd0);
    end
    chk("a_sync_err", 64'(se_a), 64'(exp_se));
    chk("b_sync_err", 64'(se_b), 64'(exp_se));
  endtask

  task automatic step(input logic v, input logic [CH-1:0] bits, input logic md, input logic fs);
    in_valid   = v;
    in_bits    = bits;
    mode       = md;
    frame_sync = fs;
    @(posedge clk);
    model_edge(v, bits, md, fs);
    #1;
    check_out();
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'({vld_a, vld_b}), 64'd0);
    chk({tag, "_vov"},   64'({vov_a, vov_b}), 64'd0);
    chk({tag, "_cnt"},   64'({cnt_a, cnt_b}), 64'd0);
    chk({tag, "_serr"},  64'({se_a, se_b}),   64'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    model_clear();
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    edge_n++;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // Thermometer: ch0 1,0,1,1; ch1 zeros.
    step(1, 2'b01, 0, 0); step(1, 2'b00, 0, 0); step(1, 2'b01, 0, 0); step(1, 2'b01, 0, 0);
    chk("therm_early", 64'(vov_a), 64'h00);
    step(0, 2'b00, 0, 0);
    chk("therm_vov", 64'(vov_a), 64'h0E);
    chk("therm_cnt", 64'(cnt_a), 64'h03);
    step(0, 2'b00, 0, 0);
    chk("therm_late", 64'(vov_a), 64'h00);

    // Raw with mode toggled mid-frame: ch0 1,0,1,1; ch1 0,1,0,0.
    step(1, 2'b01, 1, 0); step(1, 2'b10, 0, 0); step(1, 2'b01, 0, 0); step(1, 2'b01, 0, 0);
    step(0, 2'b00, 0, 0);
    chk("raw_vov", 64'(vov_a), 64'h4B);
    chk("raw_cnt", 64'(cnt_a), 64'h0B);
    idle(2);

    // Thermometer with bubbles.
    step(1, 2'b01, 0, 0); step(0, 2'b11, 1, 0); step(1, 2'b00, 0, 0); step(0, 2'b11, 1, 0);
    step(1, 2'b01, 0, 0); step(0, 2'b11, 1, 0); step(1, 2'b01, 0, 0);
    step(0, 2'b00, 0, 0);
    chk("bub_vov", 64'(vov_a), 64'h0E);
    idle(2);

    // Sync: partial frame dropped, sync on counter 0, sync on beat K-1.
    step(1, 2'b11, 0, 0); step(1, 2'b11, 0, 0);
    step(0, 2'b00, 0, 1);
    chk("sync_err_pulse", 64'(se_a), 64'd1);
    step(1, 2'b01, 1, 0); step(1, 2'b01, 0, 0); step(1, 2'b00, 0, 0); step(1, 2'b11, 0, 0);
    idle(3);
    step(0, 2'b00, 0, 1);
    chk("sync_at_zero", 64'(se_a), 64'd0);
    step(1, 2'b11, 0, 0); step(1, 2'b11, 0, 0); step(1, 2'b11, 0, 0); step(1, 2'b11, 0, 1);
    idle(4);

    // Streaming three frames, then a second run cut short by reset.
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < int'(K); b++) step(1, CH'($urandom), 1'($urandom), 0);
    idle(3);
    for (int b = 0; b < int'(K); b++) step(1, CH'($urandom), 1'($urandom), 0);
    do_reset();
    idle(4);

    // Randomized traffic with occasional sync and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, CH'($urandom), 1'($urandom),
             $urandom_range(0, 15) == 0);
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
